muldiv_unit: RTL

//  Iterative RV32M multiply/divide execute stage, directly downstream of reg_file.

---
 rtl/muldiv_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide stage: shift-add multiply, restoring divide.
// Optional MULDIV_EARLY_OUT_EN: trivial ops skip CALC and finish in one cycle.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            sysclk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op;
    logic             neg_a, neg_b, b_zero;
    logic [XLEN-1:0]  hi, lo, addend;

    logic            a_sgn, b_sgn, in_neg_a, in_neg_b;
    logic [XLEN-1:0] in_mag_a, in_mag_b;
    logic            accept, last, early;
    logic [XLEN-1:0] early_res;

    assign a_sgn = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                   (funct3 == F_DIV)  || (funct3 == F_REM);
    assign b_sgn = (funct3 == F_MULH) || (funct3 == F_DIV) ||
                   (funct3 == F_REM);
    assign in_neg_a = a_sgn && op_a[XLEN-1];
    assign in_neg_b = b_sgn && op_b[XLEN-1];
    assign in_mag_a = in_neg_a ? -op_a : op_a;
    assign in_mag_b = in_neg_b ? -op_b : op_b;

    assign accept = start && (state != CALC);
    assign last   = (cnt == CNT_W'(XLEN));

`ifdef MULDIV_EARLY_OUT_EN
    logic in_ovf;
    assign in_ovf = ((funct3 == F_DIV) || (funct3 == F_REM)) &&
                    (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);

    always_comb begin
        early     = (op_a == '0) || (op_b == '0) || in_ovf;
        early_res = '0;
        if (funct3[2]) begin
            if (op_b == '0)
                early_res = funct3[1] ? op_a : '1;
            else if (in_ovf)
                early_res = funct3[1] ? '0 : op_a;
        end
    end
`else
    assign early     = 1'b0;
    assign early_res = '0;
`endif

    // One iteration of each algorithm; {hi,lo} is the shared shift register
    logic [XLEN:0]     mul_sum, div_sh;
    logic [XLEN-1:0]   div_diff;
    logic              div_ok;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo, rem, fix_res;

    assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, addend} : '0);
    assign div_sh   = {hi, lo[XLEN-1]};
    assign div_ok   = (div_sh >= {1'b0, addend});
    assign div_diff = div_sh[XLEN-1:0] - addend;

    assign prod    = {hi, lo};
    assign prod_s  = (neg_a ^ neg_b) ? -prod : prod;
    assign quo     = b_zero ? '1 : ((neg_a ^ neg_b) ? -lo : lo);
    assign rem     = neg_a ? -hi : hi;
    assign fix_res = op[2] ? (op[1] ? rem : quo) :
                     ((op == F_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, FIN: state_nxt = start ? (early ? FIN : CALC) : IDLE;
            CALC:      if (last) state_nxt = FIN;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC);
        done = (state == FIN);
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            op     <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            b_zero <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            addend <= '0;
            result <= '0;
        end else if (accept) begin
            cnt    <= '0;
            op     <= funct3;
            neg_a  <= in_neg_a;
            neg_b  <= in_neg_b;
            b_zero <= (op_b == '0);
            hi     <= '0;
            lo     <= funct3[2] ? in_mag_a : in_mag_b;
            addend <= funct3[2] ? in_mag_b : in_mag_a;
            if (early)
                result <= early_res;
        end else if (state == CALC) begin
            if (last) begin
                result <= fix_res;
            end else begin
                cnt <= cnt + CNT_W'(1);
                if (op[2]) begin
                    hi <= div_ok ? div_diff : div_sh[XLEN-1:0];
                    lo <= {lo[XLEN-2:0], div_ok};
                end else begin
                    hi <= mul_sum[XLEN:1];
                    lo <= {mul_sum[0], lo[XLEN-1:1]};
                end
            end
        end
    end

endmodule
